group_max_broadcast: RTL and testbench

Parametrised successor to the fixed-latency max-forwarding stage of the softmax-approximation datapath. It accepts rows of one softmax group (size set by `i_length_mode`) with per-row local maxima, and computes the signed group-wide maximum. It then replays every buffered row with that global maximum attached, under valid/ready flow control. A two-bank ping-pong buffer lets one group drain while the next fills, so gaps inside a group and output backpressure are both tolerated.

---
 rtl/gmb_pkg.sv | 40 ++++
 rtl/gmb_bank.sv | 147 ++++++++++++++
 rtl/group_max_broadcast.sv | 125 ++++++++++++
 tb/tb_group_max_broadcast.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : gmb_pkg                                                      |
// | Description : Shared types and helpers for group_max_broadcast: bank      |
// |               state encoding, default index width and the mode-to-group-   |
// |               size mapping with clamp detection.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package gmb_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int GMB_MAX_ROWS = 12;
  localparam int GMB_IDX_W    = $clog2(GMB_MAX_ROWS);

  typedef struct packed {
    logic [31:0] rows;
    logic        clamped;
  } rows_t;

  // Modes 0..2 are single-row bypass groups; larger modes give mode-1 rows.
  // Anything beyond the bank depth is clamped and flagged.
  function automatic rows_t rows_from_mode(input logic [31:0] mode,
                                           input logic [31:0] max_rows);
    rows_t r;
    r.rows    = (mode <= 32'd2) ? 32'd1 : (mode - 32'd1);
    r.clamped = 1'b0;
    if (r.rows > max_rows) begin
      r.rows    = max_rows;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gmb_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gmb_bank                                                     |
// | Description : One ping-pong bank. Stores a group's rows, tracks the       |
// |               running signed maximum and replays the rows in order once   |
// |               the group is complete.                                      |
// |   i_clk/i_rst_n : clock, async active-low reset                            |
// |   i_wr          : row accepted into this bank this cycle                   |
// |   i_rd          : current replay row handed off downstream this cycle      |
// |   i_loc_max/i_mode/i_payload : incoming row                                |
// |   o_state       : EMPTY / FILLING / FULL                                   |
// |   o_fill_done   : this write completes the group                           |
// |   o_clamp_evt   : this write opens a group whose size was clamped          |
// |   o_max/o_mode/o_payload/o_rd_idx/o_last : replay view                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module gmb_bank
  import gmb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PAYLOAD_W = 1024,
  parameter int MODE_W    = 4,
  parameter int MAX_ROWS  = GMB_MAX_ROWS,
  parameter int IDX_W     = GMB_IDX_W,
  parameter int CNT_W     = $clog2(MAX_ROWS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_wr,
  input  logic                        i_rd,
  input  logic signed [DATA_W-1:0]    i_loc_max,
  input  logic        [MODE_W-1:0]    i_mode,
  input  logic        [PAYLOAD_W-1:0] i_payload,
  output bank_state_e                 o_state,
  output logic                        o_fill_done,
  output logic                        o_clamp_evt,
  output logic signed [DATA_W-1:0]    o_max,
  output logic        [MODE_W-1:0]    o_mode,
  output logic        [PAYLOAD_W-1:0] o_payload,
  output logic        [IDX_W-1:0]     o_rd_idx,
  output logic                        o_last
);

  bank_state_e               state_q,  state_d;
  logic        [CNT_W-1:0]   count_q,  count_d;
  logic        [CNT_W-1:0]   rows_q,   rows_d;
  logic signed [DATA_W-1:0]  max_q,    max_d;
  logic        [MODE_W-1:0]  mode_q,   mode_d;
  logic        [IDX_W-1:0]   rd_idx_q, rd_idx_d;

  logic [PAYLOAD_W-1:0] mem_q [MAX_ROWS];

  rows_t            w_rc;
  logic [CNT_W-1:0] w_new_rows;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_rd_inc;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_last;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rows_d      = rows_q;
    max_d       = max_q;
    mode_d      = mode_q;
    rd_idx_d    = rd_idx_q;
    o_fill_done = 1'b0;
    o_clamp_evt = 1'b0;

    w_rc       = rows_from_mode(32'(i_mode), 32'(MAX_ROWS));
    w_new_rows = CNT_W'(w_rc.rows);
    w_cnt_inc  = count_q + CNT_W'(1);
    w_rd_inc   = CNT_W'(rd_idx_q) + CNT_W'(1);
    w_last     = (w_rd_inc == rows_q);
    w_wr_idx   = (state_q == BANK_EMPTY) ? '0 : IDX_W'(count_q);

    if (i_wr) begin
      if (state_q == BANK_EMPTY) begin
        // First row opens the group: mode and size are latched only here.
        count_d     = CNT_W'(1);
        max_d       = i_loc_max;
        mode_d      = i_mode;
        rows_d      = w_new_rows;
        o_clamp_evt = w_rc.clamped;
        if (w_new_rows == CNT_W'(1)) begin
          state_d     = BANK_FULL;
          o_fill_done = 1'b1;
        end else begin
          state_d = BANK_FILLING;
        end
      end else if (state_q == BANK_FILLING) begin
        count_d = w_cnt_inc;
        if (i_loc_max > max_q) begin
          max_d = i_loc_max;
        end
        if (w_cnt_inc == rows_q) begin
          state_d     = BANK_FULL;
          o_fill_done = 1'b1;
        end
      end
    end

    if (i_rd) begin
      if (w_last) begin
        state_d  = BANK_EMPTY;
        rd_idx_d = '0;
        count_d  = '0;
      end else begin
        rd_idx_d = IDX_W'(w_rd_inc);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= BANK_EMPTY;
      count_q  <= '0;
      rows_q   <= '0;
      max_q    <= '0;
      mode_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rows_q   <= rows_d;
      max_q    <= max_d;
      mode_q   <= mode_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Row storage carries no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem_q[w_wr_idx] <= i_payload;
    end
  end

  assign o_state   = state_q;
  assign o_max     = max_q;
  assign o_mode    = mode_q;
  assign o_payload = mem_q[rd_idx_q];
  assign o_rd_idx  = rd_idx_q;
  assign o_last    = w_last;

endmodule
`default_nettype wire

// File: rtl/group_max_broadcast.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : group_max_broadcast                                          |
// | Description : Collects a softmax group of rows, finds the signed group     |
// |               maximum and replays every row with it attached. Two banks   |
// |               ping-pong so one group drains while the next fills.         |
// |   i_clk/i_rst_n/i_en : clock, async active-low reset, global enable        |
// |   i_valid/o_in_ready : input row handshake (i_loc_max, i_length_mode,     |
// |                        i_payload)                                          |
// |   o_valid/i_out_ready: output row handshake (o_global_max, o_length_mode, |
// |                        o_payload, o_row_idx, o_last)                       |
// |   o_mode_err         : one-cycle pulse when a group size was clamped       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module group_max_broadcast
  import gmb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PAYLOAD_W = 1024,
  parameter int MODE_W    = 4,
  parameter int MAX_ROWS  = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_valid,
  output logic                          o_in_ready,
  input  logic signed [DATA_W-1:0]      i_loc_max,
  input  logic        [MODE_W-1:0]      i_length_mode,
  input  logic        [PAYLOAD_W-1:0]   i_payload,
  output logic                          o_valid,
  input  logic                          i_out_ready,
  output logic signed [DATA_W-1:0]      o_global_max,
  output logic        [MODE_W-1:0]      o_length_mode,
  output logic        [PAYLOAD_W-1:0]   o_payload,
  output logic [$clog2(MAX_ROWS)-1:0]   o_row_idx,
  output logic                          o_last,
  output logic                          o_mode_err
);

  localparam int IDX_W = $clog2(MAX_ROWS);

  logic wr_sel_q,   wr_sel_d;
  logic rd_sel_q,   rd_sel_d;
  logic mode_err_q, mode_err_d;

  logic w_accept;
  logic w_handshake;

  bank_state_e               bank_state     [2];
  logic                      bank_fill_done [2];
  logic                      bank_clamp_evt [2];
  logic signed [DATA_W-1:0]  bank_max       [2];
  logic        [MODE_W-1:0]  bank_mode      [2];
  logic     [PAYLOAD_W-1:0]  bank_payload   [2];
  logic        [IDX_W-1:0]   bank_rd_idx    [2];
  logic                      bank_last      [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gmb_bank #(
      .DATA_W    (DATA_W),
      .PAYLOAD_W (PAYLOAD_W),
      .MODE_W    (MODE_W),
      .MAX_ROWS  (MAX_ROWS),
      .IDX_W     (IDX_W)
    ) u_bank (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr        (w_accept    && (int'(wr_sel_q) == b)),
      .i_rd        (w_handshake && (int'(rd_sel_q) == b)),
      .i_loc_max   (i_loc_max),
      .i_mode      (i_length_mode),
      .i_payload   (i_payload),
      .o_state     (bank_state[b]),
      .o_fill_done (bank_fill_done[b]),
      .o_clamp_evt (bank_clamp_evt[b]),
      .o_max       (bank_max[b]),
      .o_mode      (bank_mode[b]),
      .o_payload   (bank_payload[b]),
      .o_rd_idx    (bank_rd_idx[b]),
      .o_last      (bank_last[b])
    );
  end

  always_comb begin
    o_in_ready  = i_en && (bank_state[wr_sel_q] != BANK_FULL);
    o_valid     = (bank_state[rd_sel_q] == BANK_FULL);
    w_accept    = i_valid && o_in_ready;
    w_handshake = o_valid && i_out_ready && i_en;

    // Pointers are independent, so both may flip in the same cycle.
    wr_sel_d   = wr_sel_q ^ (w_accept && bank_fill_done[wr_sel_q]);
    rd_sel_d   = rd_sel_q ^ (w_handshake && bank_last[rd_sel_q]);
    mode_err_d = bank_clamp_evt[0] | bank_clamp_evt[1];

    o_global_max  = '0;
    o_length_mode = '0;
    o_payload     = '0;
    o_row_idx     = '0;
    o_last        = 1'b0;
    if (o_valid) begin
      o_global_max  = bank_max[rd_sel_q];
      o_length_mode = bank_mode[rd_sel_q];
      o_payload     = bank_payload[rd_sel_q];
      o_row_idx     = bank_rd_idx[rd_sel_q];
      o_last        = bank_last[rd_sel_q];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign o_mode_err = mode_err_q;

endmodule
`default_nettype wire

// File: tb/tb_group_max_broadcast.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_group_max_broadcast                                       |
// | Description : Scoreboard bench for group_max_broadcast. Accepted rows are |
// |               grouped by a behavioural model; completed groups push their |
// |               expected output rows, which a monitor pops and compares.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_group_max_broadcast;

  localparam int DATA_W    = 16;
  localparam int PAYLOAD_W = 1024;
  localparam int MODE_W    = 4;
  localparam int MAX_ROWS  = 12;
  localparam int IDX_W     = $clog2(MAX_ROWS);

  logic                        clk;
  logic                        rst_n;
  logic                        en;
  logic                        i_valid;
  logic                        o_in_ready;
  logic signed [DATA_W-1:0]    i_loc_max;
  logic [MODE_W-1:0]           i_length_mode;
  logic [PAYLOAD_W-1:0]        i_payload;
  logic                        o_valid;
  logic                        out_ready;
  logic signed [DATA_W-1:0]    o_global_max;
  logic [MODE_W-1:0]           o_length_mode;
  logic [PAYLOAD_W-1:0]        o_payload;
  logic [IDX_W-1:0]            o_row_idx;
  logic                        o_last;
  logic                        o_mode_err;

  group_max_broadcast #(
    .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W), .MODE_W(MODE_W), .MAX_ROWS(MAX_ROWS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(i_valid),
    .o_in_ready(o_in_ready), .i_loc_max(i_loc_max), .i_length_mode(i_length_mode),
    .i_payload(i_payload), .o_valid(o_valid), .i_out_ready(out_ready),
    .o_global_max(o_global_max), .o_length_mode(o_length_mode),
    .o_payload(o_payload), .o_row_idx(o_row_idx), .o_last(o_last),
    .o_mode_err(o_mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic signed [DATA_W-1:0] gmax;
    logic [MODE_W-1:0]        mode;
    logic [PAYLOAD_W-1:0]     payload;
    logic [IDX_W-1:0]         idx;
    logic                     last;
  } exp_t;

  exp_t                     expq [$];
  logic signed [DATA_W-1:0] gloc [$];
  logic [PAYLOAD_W-1:0]     gpay [$];
  int                       grp_r;
  logic [MODE_W-1:0]        grp_mode;
  logic                     exp_err;
  int                       stall_cnt;
  bit                       rand_phase;

  bit                       prev_stall;
  logic signed [DATA_W-1:0] prev_max;
  logic [PAYLOAD_W-1:0]     prev_pay;
  logic [IDX_W-1:0]         prev_idx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_pay(input string nm, input logic [PAYLOAD_W-1:0] act,
                         input logic [PAYLOAD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got low64 %0h expected low64 %0h at %0t",
               nm, act[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [PAYLOAD_W-1:0] gen_payload();
    logic [PAYLOAD_W-1:0] p;
    for (int w = 0; w < PAYLOAD_W / 32; w++) p[w*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic int rows_of(input int md);
    int r;
    r = (md <= 2) ? 1 : md - 1;
    return (r > MAX_ROWS) ? MAX_ROWS : r;
  endfunction

  // Monitor + reference model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      int   m;
      chk("mode_err", o_mode_err, exp_err);
      exp_err = 1'b0;

      if (prev_stall) begin
        chk("stall_valid", o_valid, 1'b1);
        chk("stall_max", o_global_max, prev_max);
        chk("stall_idx", o_row_idx, prev_idx);
        chk_pay("stall_payload", o_payload, prev_pay);
      end

      if (o_valid) begin
        if (out_ready && en) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got row idx %0d, expected no output", o_row_idx);
          end else begin
            e = expq.pop_front();
            chk("global_max", o_global_max, e.gmax);
            chk("length_mode", o_length_mode, e.mode);
            chk("row_idx", o_row_idx, e.idx);
            chk("last", o_last, e.last);
            chk_pay("payload", o_payload, e.payload);
          end
        end
      end else begin
        chk("idle_data", {o_global_max, o_length_mode, o_row_idx, o_last}, '0);
        chk_pay("idle_payload", o_payload, '0);
      end

      prev_stall = o_valid && !(out_ready && en);
      prev_max   = o_global_max;
      prev_idx   = o_row_idx;
      prev_pay   = o_payload;

      if (i_valid && en && !o_in_ready) stall_cnt++;

      if (i_valid && o_in_ready && en) begin
        if (gloc.size() == 0) begin
          grp_r    = rows_of(int'(i_length_mode));
          grp_mode = i_length_mode;
          exp_err  = ((int'(i_length_mode) - 1) > MAX_ROWS);
        end
        gloc.push_back(i_loc_max);
        gpay.push_back(i_payload);
        if (gloc.size() == grp_r) begin
          m = gloc[0];
          foreach (gloc[k]) if (int'(gloc[k]) > m) m = gloc[k];
          for (int k = 0; k < grp_r; k++) begin
            e.gmax    = DATA_W'(m);
            e.mode    = grp_mode;
            e.payload = gpay[k];
            e.idx     = IDX_W'(k);
            e.last    = (k == grp_r - 1);
            expq.push_back(e);
          end
          gloc.delete();
          gpay.delete();
        end
      end
    end
  end

  // Random backpressure / enable during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_phase) begin
        out_ready = ($urandom_range(0, 3) != 0);
        en        = ($urandom_range(0, 7) != 0);
      end
    end
  end

  task automatic send_row(input logic signed [DATA_W-1:0] lm, input logic [MODE_W-1:0] md,
                          input logic [PAYLOAD_W-1:0] pl);
    int t;
    t = 0;
    i_valid       = 1'b1;
    i_loc_max     = lm;
    i_length_mode = md;
    i_payload     = pl;
    forever begin
      @(negedge clk);
      if (o_in_ready && en) break;
      t++;
      if (t > 2000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got no o_in_ready, expected acceptance within 2000 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    expq.delete();
    gloc.delete();
    gpay.delete();
    exp_err    = 1'b0;
    prev_stall = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_mode_err", o_mode_err, 1'b0);
      chk("rst_data", {o_global_max, o_length_mode, o_row_idx, o_last}, '0);
      chk_pay("rst_payload", o_payload, '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", o_in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    int md;
    logic signed [DATA_W-1:0] lm;
    rst_n = 1'b0; en = 1'b1; i_valid = 1'b0; out_ready = 1'b1;
    i_loc_max = '0; i_length_mode = '0; i_payload = '0;
    exp_err = 1'b0; stall_cnt = 0; rand_phase = 1'b0; prev_stall = 1'b0;
    prev_max = '0; prev_pay = '0; prev_idx = '0; grp_r = 1; grp_mode = '0;

    repeat (2) @(negedge clk);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_mode_err", o_mode_err, 1'b0);
    chk_pay("reset_payload", o_payload, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Mode 3 gap-less; first output one cycle after last input.
    send_row(16'sd100, 4'd3, gen_payload());
    send_row(16'sd101, 4'd3, gen_payload());
    @(negedge clk);
    chk("latency_valid", o_valid, 1'b1);
    wait_drain();

    // Mode 13 then mode 4 back-to-back, no input stall expected.
    stall_cnt = 0;
    for (int k = 0; k < 12; k++) send_row(DATA_W'(200 + k), (k == 0) ? 4'd13 : 4'($urandom), gen_payload());
    for (int k = 0; k < 3; k++)  send_row(DATA_W'(300 + k), (k == 0) ? 4'd4 : 4'($urandom), gen_payload());
    chk("b2b_no_stall", stall_cnt, 0);
    wait_drain();

    // Signed max with gaps.
    send_row(-16'sd5, 4'd5, gen_payload());   idle(2);
    send_row(-16'sd1, 4'd5, gen_payload());   idle(1);
    send_row(-16'sd300, 4'd5, gen_payload()); idle(3);
    send_row(-16'sd2, 4'd5, gen_payload());
    wait_drain();

    // Backpressure: two groups buffered, then input must stall.
    idle(1);
    out_ready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      send_row(DATA_W'(10 * g), 4'd3, gen_payload());
      send_row(DATA_W'(10 * g + 5), 4'd3, gen_payload());
    end
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", o_in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_row(16'sd77, 4'd3, gen_payload());
    send_row(16'sd70, 4'd3, gen_payload());
    wait_drain();

    // Bypass and clamp.
    send_row(16'sd999, 4'd0, gen_payload());
    wait_drain();
    for (int k = 0; k < 12; k++) send_row(DATA_W'($urandom), (k == 0) ? 4'd15 : 4'($urandom), gen_payload());
    wait_drain();

    // Reset mid-group, then a fresh mode-3 group.
    send_row(16'sd1, 4'd5, gen_payload());
    send_row(16'sd2, 4'd5, gen_payload());
    do_reset();
    send_row(-16'sd7, 4'd3, gen_payload());
    send_row(-16'sd8, 4'd3, gen_payload());
    wait_drain();

    // Randomised groups with random gaps, backpressure and enable.
    rand_phase = 1'b1;
    for (int g = 0; g < 40; g++) begin
      md = $urandom_range(0, 15);
      for (int k = 0; k < rows_of(md); k++) begin
        lm = ($urandom_range(0, 1) != 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 6)) - 16'sd3;
        send_row(lm, (k == 0) ? MODE_W'(md) : MODE_W'($urandom), gen_payload());
        idle($urandom_range(0, 2));
      end
    end
    rand_phase = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    en        = 1'b1;
    wait_drain();
    chk("no_partial_group", gloc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
